// File: rtl/fp_addsub_ctrl.sv
// Sequencer for the FP add/sub datapath: strobes stage loads in order and runs
// an iterative one-bit-per-cycle normalizer; holds control state only.
//
// state | meaning
// IDLE  | ready for a new operation
// LOAD  | operand registers load; per-op flags and shift counter cleared
// ALIGN | exponent compare / mantissa adjust; special operands detected
// ADD   | sum register load
// NORM  | one normalizer step per cycle until a status or the limit stops it
// ROUND | rounding; a carry out triggers one renormalization pass
// PACK  | result register load
// DONE  | result valid, waiting for ack
module fp_addsub_ctrl #(
    parameter int DATA_WIDTH  = 52,
    parameter int SHAMT_WIDTH = 11
) (
    input  logic                   in_clk,
    input  logic                   in_rst,
    input  logic                   in_start,
    input  logic                   in_op,
    input  logic                   in_ack,
    input  logic                   in_special,
    input  logic                   in_sumZero,
    input  logic                   in_sumOverflow,
    input  logic                   in_sumMsb,
    input  logic                   in_expUnderflow,
    input  logic                   in_roundCarry,
    output logic                   out_ready,
    output logic                   out_opSub,
    output logic                   out_ldOperands,
    output logic                   out_ldAligned,
    output logic                   out_ldSum,
    output logic                   out_round,
    output logic                   out_ldResult,
    output logic                   out_shiftRight1,
    output logic                   out_expInc,
    output logic                   out_shiftLeft1,
    output logic                   out_expDec,
    output logic                   out_selSpecial,
    output logic                   out_valid,
    output logic [SHAMT_WIDTH-1:0] out_normCount
);

    typedef enum logic [2:0] {
        IDLE, LOAD, ALIGN, ADD, NORM, ROUND, PACK, DONE
    } state_t;

    localparam logic [SHAMT_WIDTH-1:0] NORM_LIMIT = SHAMT_WIDTH'(DATA_WIDTH + 2);

    state_t                 state;
    state_t                 nextState;
    logic                   opSub;
    logic                   specialFlag;
    logic                   reroundFlag;
    logic [SHAMT_WIDTH-1:0] normCount;
    logic                   normExit;

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state       <= IDLE;
            opSub       <= 1'b0;
            specialFlag <= 1'b0;
            reroundFlag <= 1'b0;
            normCount   <= '0;
        end else begin
            state <= nextState;
            case (state)
                IDLE:    if (in_start) opSub <= in_op;
                LOAD: begin
                    normCount   <= '0;
                    specialFlag <= 1'b0;
                    reroundFlag <= 1'b0;
                end
                ALIGN:   if (in_special) specialFlag <= 1'b1;
                NORM:    if (out_shiftLeft1) normCount <= normCount + 1'b1;
                ROUND:   if (in_roundCarry && !reroundFlag) reroundFlag <= 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        nextState       = state;
        normExit        = 1'b0;
        out_ready       = 1'b0;
        out_ldOperands  = 1'b0;
        out_ldAligned   = 1'b0;
        out_ldSum       = 1'b0;
        out_round       = 1'b0;
        out_ldResult    = 1'b0;
        out_shiftRight1 = 1'b0;
        out_expInc      = 1'b0;
        out_shiftLeft1  = 1'b0;
        out_expDec      = 1'b0;
        out_selSpecial  = 1'b0;
        out_valid       = 1'b0;
        case (state)
            IDLE: begin
                out_ready = 1'b1;
                if (in_start) nextState = LOAD;
            end
            LOAD: begin
                out_ldOperands = 1'b1;
                nextState      = ALIGN;
            end
            ALIGN: begin
                out_ldAligned = 1'b1;
                nextState     = in_special ? PACK : ADD;
            end
            ADD: begin
                out_ldSum = 1'b1;
                nextState = NORM;
            end
            NORM: begin
                // Status priority: zero, overflow, msb set, exponent floor, shift limit.
                if (in_sumZero) begin
                    normExit = 1'b1;
                end else if (in_sumOverflow) begin
                    out_shiftRight1 = 1'b1;
                    out_expInc      = 1'b1;
                    normExit        = 1'b1;
                end else if (in_sumMsb || in_expUnderflow || normCount == NORM_LIMIT) begin
                    normExit = 1'b1;
                end else begin
                    out_shiftLeft1 = 1'b1;
                    out_expDec     = 1'b1;
                end
                if (normExit) nextState = reroundFlag ? PACK : ROUND;
            end
            ROUND: begin
                out_round = 1'b1;
                nextState = (in_roundCarry && !reroundFlag) ? NORM : PACK;
            end
            PACK: begin
                out_ldResult   = 1'b1;
                out_selSpecial = specialFlag;
                nextState      = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (in_ack) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    assign out_opSub     = opSub;
    assign out_normCount = normCount;

endmodule

// File: tb/tb_fp_addsub_ctrl.sv
// Scoreboard bench: each operation's expected stage trace is built from the
// sequencing rules and compared by an independent monitor when out_valid rises.
module tb_fp_addsub_ctrl;

    localparam int DW    = 52;
    localparam int SW    = 11;
    localparam int LIMIT = DW + 2;

    logic          clk = 1'b0;
    logic          in_rst, in_start, in_op, in_ack, in_special;
    logic          in_sumZero, in_sumOverflow, in_sumMsb, in_expUnderflow, in_roundCarry;
    logic          out_ready, out_opSub, out_ldOperands, out_ldAligned, out_ldSum;
    logic          out_round, out_ldResult, out_shiftRight1, out_expInc;
    logic          out_shiftLeft1, out_expDec, out_selSpecial, out_valid;
    logic [SW-1:0] out_normCount;

    always #5 clk = ~clk;

    fp_addsub_ctrl #(.DATA_WIDTH(DW), .SHAMT_WIDTH(SW)) dut (
        .in_clk(clk), .in_rst(in_rst), .in_start(in_start), .in_op(in_op),
        .in_ack(in_ack), .in_special(in_special), .in_sumZero(in_sumZero),
        .in_sumOverflow(in_sumOverflow), .in_sumMsb(in_sumMsb),
        .in_expUnderflow(in_expUnderflow), .in_roundCarry(in_roundCarry),
        .out_ready(out_ready), .out_opSub(out_opSub), .out_ldOperands(out_ldOperands),
        .out_ldAligned(out_ldAligned), .out_ldSum(out_ldSum), .out_round(out_round),
        .out_ldResult(out_ldResult), .out_shiftRight1(out_shiftRight1),
        .out_expInc(out_expInc), .out_shiftLeft1(out_shiftLeft1),
        .out_expDec(out_expDec), .out_selSpecial(out_selSpecial),
        .out_valid(out_valid), .out_normCount(out_normCount)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic checkStr(input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got '%s' expected '%s'", name, act, exp);
        end
    endtask

    // Scoreboard: one entry per accepted operation
    string sbTrace[$];
    bit    sbOp[$];
    int    sbCount[$];
    int    sbAck[$];

    // Reference model output for the operation being built.
    // Trace chars: O load, A align, S sum, R round, P pack, Q pack-special,
    // < left shift, > right shift, . cycle without strobes.
    // Vec bits: [5] special [4] zero [3] overflow [2] msb [1] underflow [0] roundCarry
    string      mTrace;
    logic [5:0] mVec[$];
    int         mCnt;

    function automatic logic [5:0] randVec();
        return 6'($urandom);
    endfunction

    task automatic addStep(input string ch, input logic [5:0] v);
        mTrace = {mTrace, ch};
        mVec.push_back(v);
    endtask

    // exitKind: 0 msb, 1 overflow, 2 zero, 3 underflow, 4 shift limit reached
    task automatic normPass(input int k, input int exitKind);
        logic [5:0] v;
        for (int i = 0; i < k; i++) begin
            v = randVec();
            v[4:1] = 4'b0000;
            addStep("<", v);
            mCnt++;
        end
        v = randVec();
        case (exitKind)
            0: begin v[4] = 1'b0; v[3] = 1'b0; v[2] = 1'b1; addStep(".", v); end
            1: begin v[4] = 1'b0; v[3] = 1'b1; addStep(">", v); end
            2: begin v[4] = 1'b1; addStep(".", v); end
            3: begin v[4:2] = 3'b000; v[1] = 1'b1; addStep(".", v); end
            default: begin v[4:1] = 4'b0000; addStep(".", v); end
        endcase
    endtask

    task automatic buildModel(input bit special, input int k1, input int e1,
                              input bit rc, input int k2, input int e2);
        logic [5:0] v;
        mTrace = "";
        mVec.delete();
        mCnt = 0;
        addStep("O", randVec());
        v = randVec(); v[5] = special;
        addStep("A", v);
        if (special) begin
            addStep("Q", randVec());
        end else begin
            addStep("S", randVec());
            normPass(k1, e1);
            v = randVec(); v[0] = rc;
            addStep("R", v);
            if (rc) normPass(k2, e2);
            addStep("P", randVec());
        end
    endtask

    task automatic applyVec(input logic [5:0] v);
        in_special      = v[5];
        in_sumZero      = v[4];
        in_sumOverflow  = v[3];
        in_sumMsb       = v[2];
        in_expUnderflow = v[1];
        in_roundCarry   = v[0];
    endtask

    // Called at posedge+1 of an idle cycle; returns at posedge+1 of the idle cycle after ack.
    task automatic driveOp(input bit op, input int ackDelay, input int stopAt);
        repeat ($urandom_range(0, 2)) begin
            in_start = 1'b0;
            applyVec(randVec());
            @(posedge clk); #1;
        end
        in_start = 1'b1;
        in_op    = op;
        applyVec(randVec());
        @(posedge clk); #1;
        for (int c = 0; c < mVec.size(); c++) begin
            if (c == stopAt) return;
            applyVec(mVec[c]);
            in_start = 1'($urandom);
            in_op    = 1'($urandom);
            in_ack   = 1'($urandom);
            @(posedge clk); #1;
        end
        for (int j = 0; j < ackDelay; j++) begin
            in_ack   = 1'b0;
            in_start = 1'b1;
            applyVec(randVec());
            @(posedge clk); #1;
        end
        in_ack   = 1'b1;
        in_start = 1'b1;
        @(posedge clk); #1;
        in_ack   = 1'b0;
        in_start = 1'b0;
    endtask

    task automatic runOp(input bit op, input bit special, input int k1, input int e1,
                         input bit rc, input int k2, input int e2, input int ackDelay);
        buildModel(special, k1, e1, rc, k2, e2);
        sbTrace.push_back(mTrace);
        sbOp.push_back(op);
        sbCount.push_back(special ? 0 : mCnt);
        sbAck.push_back(ackDelay);
        driveOp(op, ackDelay, -1);
    endtask

    task automatic randomOp();
        int k1, e1, k2, e2, rem, r;
        bit rc;
        r  = int'($urandom_range(0, 9));
        k1 = (r == 0) ? LIMIT : (r < 3) ? int'($urandom_range(0, LIMIT)) : int'($urandom_range(0, 5));
        e1 = (k1 == LIMIT) ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 3));
        rc = ($urandom_range(0, 2) == 0);
        rem = LIMIT - k1;
        k2 = ($urandom_range(0, 3) == 0) ? rem : int'($urandom_range(0, (rem < 4) ? rem : 4));
        e2 = (k2 == rem) ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 3));
        runOp(1'($urandom), ($urandom_range(0, 4) == 0), k1, e1, rc, k2, e2,
              int'($urandom_range(0, 4)));
    endtask

    task automatic checkResetOutputs(input string name);
        check({name, "_ready"}, 64'(out_ready), 64'd1);
        check({name, "_outputs"}, 64'({out_opSub, out_ldOperands, out_ldAligned, out_ldSum,
              out_round, out_ldResult, out_shiftRight1, out_expInc, out_shiftLeft1,
              out_expDec, out_selSpecial, out_valid}), 64'd0);
        check({name, "_normCount"}, 64'(out_normCount), 64'd0);
    endtask

    // Monitor
    string trace;
    bit    tracing  = 1'b0;
    bit    validRun = 1'b0;
    int    validCnt;
    int    curAck;
    int    stageCnt;

    function automatic string stepChar();
        if (out_selSpecial && !out_ldResult) return "?";
        if (out_ldOperands)  return "O";
        if (out_ldAligned)   return "A";
        if (out_ldSum)       return "S";
        if (out_round)       return "R";
        if (out_ldResult)    return out_selSpecial ? "Q" : "P";
        if (out_shiftLeft1)  return "<";
        if (out_shiftRight1) return ">";
        return ".";
    endfunction

    always @(negedge clk) begin
        stageCnt = int'(out_ldOperands) + int'(out_ldAligned) + int'(out_ldSum)
                 + int'(out_round) + int'(out_ldResult);
        check("strobe_exclusive", 64'((stageCnt <= 1) && !(out_shiftLeft1 && out_shiftRight1)
              && (out_shiftRight1 == out_expInc) && (out_shiftLeft1 == out_expDec)), 64'd1);
        if (in_rst) begin
            tracing  = 1'b0;
            validRun = 1'b0;
        end else begin
            if (tracing) begin
                if (out_valid) begin
                    tracing = 1'b0;
                    if (sbTrace.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_valid: got trace '%s' expected no result", trace);
                    end else begin
                        checkStr("stage_trace", trace, sbTrace.pop_front());
                        check("opSub", 64'(out_opSub), 64'(sbOp.pop_front()));
                        check("normCount", 64'(out_normCount), 64'(sbCount.pop_front()));
                        curAck   = sbAck.pop_front();
                        validCnt = 1;
                        validRun = 1'b1;
                    end
                end else begin
                    trace = {trace, stepChar()};
                    if (trace.len() > 200) begin
                        checks++;
                        errors++;
                        $display("FAIL valid_timeout: got no out_valid after %0d cycles expected at most 200", trace.len());
                        tracing = 1'b0;
                    end
                end
            end else if (validRun) begin
                if (out_valid) begin
                    validCnt++;
                end else begin
                    check("valid_hold", 64'(validCnt), 64'(curAck + 1));
                    check("ready_after_ack", 64'(out_ready), 64'd1);
                    validRun = 1'b0;
                end
            end else begin
                check("idle_quiet", 64'({out_ldOperands, out_ldAligned, out_ldSum, out_round,
                      out_ldResult, out_shiftRight1, out_shiftLeft1, out_selSpecial, out_valid}), 64'd0);
            end
            if (!tracing && !validRun && out_ready && in_start) begin
                tracing = 1'b1;
                trace   = "";
            end
        end
    end

    initial begin
        in_rst = 1'b1;
        in_start = 1'b0;
        in_op = 1'b0;
        in_ack = 1'b0;
        applyVec(6'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("reset");
        @(posedge clk); #1;
        in_rst = 1'b0;

        runOp(1'b1, 1'b0, 0, 0, 1'b0, 0, 0, 0);      // basic sub, msb already set
        runOp(1'b0, 1'b0, 3, 0, 1'b0, 0, 0, 1);      // three left shifts
        runOp(1'b1, 1'b0, 0, 1, 1'b1, 0, 1, 0);      // overflow, round carry, overflow again
        runOp(1'b0, 1'b1, 0, 0, 1'b0, 0, 0, 2);      // special operand
        runOp(1'b1, 1'b0, LIMIT, 4, 1'b0, 0, 0, 0);  // shift limit
        runOp(1'b0, 1'b0, 2, 3, 1'b0, 0, 0, 4);      // valid held 5 cycles, start during DONE

        // Reset during the 4th NORM cycle abandons the operation
        buildModel(1'b0, 20, 0, 1'b0, 0, 0);
        driveOp(1'b1, 0, 6);
        in_rst   = 1'b1;
        in_start = 1'b0;
        @(posedge clk); #1;
        in_rst = 1'b0;
        @(negedge clk);
        checkResetOutputs("midop_reset");
        @(posedge clk); #1;

        runOp(1'b0, 1'b0, 1, 2, 1'b0, 0, 0, 0);
        for (int n = 0; n < 80; n++) randomOp();

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", 64'(sbTrace.size()), 64'd0);
        check("monitor_idle", 64'(tracing || validRun), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
